// File: rtl/exec_unit.sv
// RV32I execute unit: ALU, branch compare and optional iterative M-extension behind a valid/ready handshake.
// Single-cycle ops are valid one edge after accept and mul/div after XLEN+1 edges; DONE holds the result until out_ready.
module exec_unit #(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALU_op,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  input  logic            funct7_0,
  input  logic            op5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [SHW-1:0]    cnt;
  logic              q_neg;
  logic              r_neg;
  logic              sel_hi;
  logic              sel_rem;
  logic [XLEN-1:0]   result_q;
  logic              branch_q;
  logic              illegal_q;

  assign in_ready     = (state == IDLE);
  assign busy         = (state != IDLE);
  assign out_valid    = (state == DONE);
  assign result       = result_q;
  assign branch_taken = branch_q;
  assign illegal      = illegal_q;

  logic           is_m;
  logic [SHW-1:0] shamt;
  logic           signed_lt;
  logic           unsigned_lt;

  assign is_m        = (ALU_op == 2'b10) && op5 && funct7_0;
  assign shamt       = src_b[SHW-1:0];
  assign signed_lt   = $signed(src_a) < $signed(src_b);
  assign unsigned_lt = src_a < src_b;

  logic [XLEN-1:0] alu_res;
  logic            alu_br;
  logic            dec_illegal;

  always_comb begin
    alu_res     = '0;
    alu_br      = 1'b0;
    dec_illegal = 1'b0;
    case (ALU_op)
      2'b00: alu_res = src_a + src_b;
      2'b01: begin
        alu_res = src_a - src_b;
        case (funct3)
          3'b000:  alu_br = (src_a == src_b);
          3'b001:  alu_br = (src_a != src_b);
          3'b100:  alu_br = signed_lt;
          3'b101:  alu_br = !signed_lt;
          3'b110:  alu_br = unsigned_lt;
          3'b111:  alu_br = !unsigned_lt;
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        if (is_m) begin
          dec_illegal = !M_EXT;
        end else begin
          case (funct3)
            3'b000: begin
              if (op5 && funct7) alu_res = src_a - src_b;
              else               alu_res = src_a + src_b;
            end
            3'b001: alu_res = src_a << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, signed_lt};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, unsigned_lt};
            3'b100: alu_res = src_a ^ src_b;
            3'b101: begin
              // kept as separate statements so >>> stays in a signed context
              if (funct7) alu_res = $signed(src_a) >>> shamt;
              else        alu_res = src_a >> shamt;
            end
            3'b110: alu_res = src_a | src_b;
            default: alu_res = src_a & src_b;
          endcase
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      alu_res = '0;
      alu_br  = 1'b0;
    end
  end

  logic            a_sgn;
  logic            b_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] div_special;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010:  a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign a_neg    = a_sgn && src_a[XLEN-1];
  assign b_neg    = b_sgn && src_b[XLEN-1];
  assign a_mag    = a_neg ? -src_a : src_a;
  assign b_mag    = b_neg ? -src_b : src_b;
  assign div_zero = (src_b == '0);
  assign div_ovf  = a_sgn && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b);

  always_comb begin
    if (funct3[1]) div_special = div_zero ? src_a : '0;
    else           div_special = div_zero ? '1 : src_a;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_fixed;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_q;
  logic [XLEN-1:0]   div_r;
  logic [XLEN-1:0]   div_res;
  logic              last_iter;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
  assign mul_next  = {mul_sum, acc[XLEN-1:1]};
  assign mul_fixed = q_neg ? -mul_next : mul_next;
  assign mul_res   = sel_hi ? mul_fixed[2*XLEN-1:XLEN] : mul_fixed[XLEN-1:0];

  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign div_q     = div_next[XLEN-1:0];
  assign div_r     = div_next[2*XLEN-1:XLEN];
  assign div_res   = sel_rem ? (r_neg ? -div_r : div_r) : (q_neg ? -div_q : div_q);
  assign last_iter = (cnt == SHW'(XLEN-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      opnd      <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      sel_hi    <= 1'b0;
      sel_rem   <= 1'b0;
      result_q  <= '0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_m && M_EXT) begin
              branch_q  <= 1'b0;
              illegal_q <= 1'b0;
              if (funct3[2] && (div_zero || div_ovf)) begin
                result_q <= div_special;
                state    <= DONE;
              end else begin
                acc     <= {{XLEN{1'b0}}, a_mag};
                opnd    <= b_mag;
                cnt     <= '0;
                q_neg   <= a_neg ^ b_neg;
                r_neg   <= a_neg;
                sel_hi  <= |funct3[1:0];
                sel_rem <= funct3[1];
                state   <= funct3[2] ? DIV : MUL;
              end
            end else begin
              result_q  <= alu_res;
              branch_q  <= alu_br;
              illegal_q <= dec_illegal;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            result_q <= mul_res;
            state    <= DONE;
          end
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            result_q <= div_res;
            state    <= DONE;
          end
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed vector table, multi-cycle corner sequences and randomized ops vs a reference model.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALU_op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        funct7_0;
  logic        op5;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        illegal;
  logic        busy;

  always #5 clk = ~clk;

  exec_unit #(.XLEN(32), .M_EXT(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_op(ALU_op), .funct3(funct3), .funct7(funct7), .funct7_0(funct7_0), .op5(op5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch_taken(branch_taken), .illegal(illegal), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        f70;
    logic        o5;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    logic        ill;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic f7, f70, o5,
                              input logic [31:0] a, b, res, input logic br, ill, input int lat);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.f70 = f70; v.o5 = o5;
    v.a = a; v.b = b; v.res = res; v.br = br; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Reference model: RISC-V semantics on 64-bit integers, latency by operation class.
  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic f7, f70, o5,
                                input logic [31:0] a, b, output logic [31:0] r,
                                output logic br, output logic ill, output int lat);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0; br = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      2'b00: r = a + b;
      2'b01: begin
        r = a - b;
        case (f3)
          3'd0: br = (a == b);
          3'd1: br = (a != b);
          3'd4: br = (sa < sb);
          3'd5: br = (sa >= sb);
          3'd6: br = (a < b);
          3'd7: br = (a >= b);
          default: begin ill = 1'b1; r = '0; end
        endcase
      end
      2'b10: begin
        if (o5 && f70) begin
          lat = 33;
          case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: begin
              if (b == 0)   begin r = 32'hFFFF_FFFF; lat = 1; end
              else if (ovf) begin r = a; lat = 1; end
              else          r = 32'(sa / sb);
            end
            3'd5: begin
              if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
              else        r = a / b;
            end
            3'd6: begin
              if (b == 0)   begin r = a; lat = 1; end
              else if (ovf) begin r = 0; lat = 1; end
              else          r = 32'(sa % sb);
            end
            default: begin
              if (b == 0) begin r = a; lat = 1; end
              else        r = a % b;
            end
          endcase
        end else begin
          case (f3)
            3'd0: r = (o5 && f7) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = f7 ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
          endcase
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Issue one op, scramble inputs after accept, wait for out_valid (bounded), then hand-shake.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic f7, f70, o5,
                        input logic [31:0] a, b, output logic [31:0] r,
                        output logic br, output logic ill, output int lat);
    ALU_op = op; funct3 = f3; funct7 = f7; funct7_0 = f70; op5 = o5;
    src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a = $urandom; src_b = $urandom; funct3 = 3'($urandom); ALU_op = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; br = branch_taken; ill = illegal;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[16];

  initial begin
    logic [31:0] r;
    logic        br;
    logic        ill;
    int          lat;
    logic [31:0] er;
    logic        ebr;
    logic        eill;
    int          elat;
    logic [31:0] held;
    int          vcount;

    vecs[0]  = mk(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    vecs[1]  = mk(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1);
    vecs[2]  = mk(2'b01, 3'b110, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1);
    vecs[3]  = mk(2'b01, 3'b100, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1);
    vecs[4]  = mk(2'b01, 3'b010, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1);
    vecs[5]  = mk(2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33);
    vecs[6]  = mk(2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    vecs[7]  = mk(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 1'b0, 33);
    vecs[8]  = mk(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, 33);
    vecs[9]  = mk(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    vecs[10] = mk(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    vecs[11] = mk(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1);
    vecs[12] = mk(2'b00, 3'b011, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    vecs[13] = mk(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1);
    vecs[14] = mk(2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    vecs[15] = mk(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd7, 1'b0, 1'b0, 33);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALU_op = 2'b00; funct3 = 3'b000; funct7 = 1'b0; funct7_0 = 1'b0; op5 = 1'b0;
    src_a = '0; src_b = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_branch", branch_taken, 0);
    check("rst_illegal", illegal, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].f70, vecs[i].o5, vecs[i].a, vecs[i].b,
             r, br, ill, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_branch", i), br, vecs[i].br);
      check($sformatf("vec%0d_illegal", i), ill, vecs[i].ill);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Reset in the middle of a divide aborts it.
    ALU_op = 2'b10; funct3 = 3'b100; funct7 = 1'b0; funct7_0 = 1'b1; op5 = 1'b1;
    src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("div_busy", busy, 1);
    check("div_in_ready", in_ready, 0);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 1);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) vcount++;
    end
    check("midrst_no_result", vcount, 0);
    run_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, r, br, ill, lat);
    check("midrst_add_result", r, 7);
    check("midrst_add_latency", lat, 1);

    // Backpressure on a multiply, with in_valid pulses while busy.
    ALU_op = 2'b10; funct3 = 3'b000; funct7 = 1'b0; funct7_0 = 1'b1; op5 = 1'b1;
    src_a = 32'hFFFF_FFFD; src_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ALU_op = 2'b00; src_a = 32'd1000; src_b = 32'd1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      in_valid = ~in_valid;
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 33);
    check("bp_result", result, 32'hFFFF_FFEB);
    held = result;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_result", k), result, held);
      check($sformatf("bp_hold%0d_valid", k), out_valid, 1);
      check($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // out_ready already high: completes on the first DONE cycle.
    out_ready = 1'b1;
    ALU_op = 2'b10; funct3 = 3'b111; funct7 = 1'b0; funct7_0 = 1'b0; op5 = 1'b1;
    src_a = 32'h0000_F0F0; src_b = 32'h0000_FF00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("early_rdy_valid", out_valid, 1);
    check("early_rdy_result", result, 32'h0000_F000);
    @(posedge clk); #1;
    check("early_rdy_done", out_valid, 0);
    check("early_rdy_in_ready", in_ready, 1);
    out_ready = 1'b0;

    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        f70;
      logic        o5;
      logic [31:0] a;
      logic [31:0] b;
      op  = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      f7  = 1'($urandom_range(0, 1));
      f70 = 1'($urandom_range(0, 1));
      o5  = 1'($urandom_range(0, 1));
      if (op == 2'b10 && $urandom_range(0, 1) == 1) begin
        o5 = 1'b1; f70 = 1'b1;
      end
      a = pick();
      b = pick();
      model(op, f3, f7, f70, o5, a, b, er, ebr, eill, elat);
      run_op(op, f3, f7, f70, o5, a, b, r, br, ill, lat);
      check($sformatf("rand%0d_result", i), r, er);
      check($sformatf("rand%0d_branch", i), br, ebr);
      check($sformatf("rand%0d_illegal", i), ill, eill);
      check($sformatf("rand%0d_latency", i), lat, elat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised execute unit for the RV32I core: the successor to the single-cycle ALU decoder. It decodes ALU_op/funct3/funct7/op5 directly into an operation, executes it, and returns a registered result over a valid/ready handshake. It covers the full RV32I ALU and branch-compare set, and optionally the M extension using an iterative multiplier and divider. It sits between the main control unit/register-file read stage and write-back/branch logic.

## Interface
- XLEN, 32, datapath width (power of two, ≥8).
- M_EXT, 1, 1 enables mul/div ops; 0 flags them illegal.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; 1 only in IDLE.
- ALU_op  in  2  00 address add, 01 branch compare, 10 R/I arithmetic, 11 illegal.
- funct3  in  3  instr[14:12].
- funct7  in  1  instr[30].
- funct7_0  in  1  instr[25] (M-extension select).
- op5  in  1  instr[5] (1 = R-type).
- src_a, src_b  in  XLEN  operands.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- branch_taken  out  1  branch condition true (ALU_op=01 only).
- illegal  out  1  undecodable request.
- busy  out  1  state ≠ IDLE.

## Operation
- Accept when in_valid & in_ready. All inputs are captured at accept; later input changes are ignored. in_valid while not ready is ignored.
- ALU_op=00: result = src_a+src_b.
- ALU_op=01: result = src_a−src_b. branch_taken per funct3: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu. funct3 010/011 → illegal.
- ALU_op=10, non-M:
  - 000: sub if op5&funct7, else add.
  - 001: sll.
  - 010: slt.
  - 011: sltu.
  - 100: xor.
  - 101: sra if funct7, else srl.
  - 110: or.
  - 111: and.
  - Shift amount = src_b[log2(XLEN)−1:0].
  - slt/sltu yield 0/1 zero-extended.
- ALU_op=10, op5=1, funct7_0=1, M_EXT=1:
  - funct3 000–011: mul, mulh, mulhsu, mulhu.
  - funct3 100–111: div, divu, rem, remu.
  - With M_EXT=0 the same encoding → illegal.
- Multiply: shift-add on operand magnitudes, one bit per cycle, 2·XLEN product, sign fixed at end. mul returns the low XLEN bits; the mulh variants return the high XLEN bits. mulhsu treats src_a as signed and src_b as unsigned.
- Divide: restoring, one quotient bit per cycle, on magnitudes. Quotient is negative if operand signs differ; remainder takes the dividend's sign.
- Divide-by-zero: quotient all-ones, remainder = src_a, no iteration.
- Signed overflow (src_a = most-negative, src_b = −1): quotient = src_a, remainder 0, no iteration.
- Illegal: result 0, illegal=1, branch_taken 0.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE→DONE on accept of a single-cycle op, an illegal op, or a div special case.
  - IDLE→MUL / IDLE→DIV on accept of an iterative op.
  - MUL/DIV→DONE after XLEN iteration cycles.
  - DONE→IDLE when out_ready.
- result, branch_taken and illegal are meaningful only while out_valid. They hold stable in DONE until out_ready.

## Timing
- Reset (async assert): state IDLE, out_valid 0, result 0, branch_taken 0, illegal 0, busy 0, internal accumulators 0. Release is synchronous to clk.
- Reset mid-MUL/DIV or in DONE aborts the operation; no result is emitted.
- Single-cycle ops, illegal ops and div special cases: accept at edge N, out_valid=1 after edge N+1.
- mul/div: accept at edge N, out_valid=1 after edge N+XLEN+1. busy=1 from N to the handshake.
- out_valid & out_ready at edge M: out_valid=0 and in_ready=1 after M. The next accept is at M+1 at the earliest. Throughput is one op per 2 cycles minimum.
- out_ready held high before out_valid: completion occurs on the first DONE cycle.
- in_ready depends on state only. There is no combinational path from any input to any output.

## Test plan
- Reset mid-DIV (assert at cycle 10): out_valid=0, in_ready=1 after release, and the next ADD completes normally.
- ALU_op=10, op5=1, funct7=1, funct3=000, a=5, b=7: result=0xFFFFFFFE after 1 cycle. funct3=101, funct7=1, a=0x80000000, b=4: result=0xF8000000.
- ALU_op=01, funct3=110, a=1, b=0xFFFFFFFF: branch_taken=1. funct3=100, same operands: branch_taken=0. funct3=010: illegal=1, result=0.
- mulh, a=0xFFFFFFFF, b=0xFFFFFFFF: result=0 at accept+33. mulhu, same operands: result=0xFFFFFFFE. mul, a=−3, b=7: result=0xFFFFFFEB.
- div, a=−7, b=2: quotient 0xFFFFFFFD. rem: 0xFFFFFFFF. divu, b=0: 0xFFFFFFFF at accept+1. div, 0x80000000/−1: 0x80000000 at accept+1.
- Backpressure: out_ready held 0 for 5 cycles after out_valid → result stable and in_ready=0 throughout. in_valid pulses during MUL are not captured.
